// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the data-bus arbiter.
package bus_pkg;
   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned HOLD_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first requesting source at or after ptr, wrapping 7->0.
module rr_picker
   import bus_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      // Candidate index wraps naturally in SEL_W bits.
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         cand = ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin data-bus arbiter with a hold limit and a one-cycle turnaround gap.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
   output logic [NUM_SRC-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               bus_valid
);

   arb_state_e        state;
   logic [SEL_W-1:0]  ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic              pick_found;
   logic [SEL_W-1:0]  pick_idx;
   logic              release_now;

   rr_picker u_picker (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // In GRANT, sel always holds the current owner.
   always_comb begin
      release_now = !req[sel] || (hold_cnt == HOLD_W'(MAX_HOLD));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         sel       <= '0;
         bus_valid <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_GAP: begin
               if (pick_found) begin
                  state     <= ST_GRANT;
                  gnt       <= NUM_SRC'(1) << pick_idx;
                  sel       <= pick_idx;
                  bus_valid <= 1'b1;
                  hold_cnt  <= HOLD_W'(1);
               end else begin
                  state     <= ST_IDLE;
                  gnt       <= '0;
                  bus_valid <= 1'b0;
                  hold_cnt  <= '0;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  state     <= ST_GAP;
                  gnt       <= '0;
                  bus_valid <= 1'b0;
                  ptr       <= sel + SEL_W'(1);
                  hold_cnt  <= '0;
               end else begin
                  hold_cnt  <= hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               gnt       <= '0;
               bus_valid <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule
